mips_memory_io: RTL and testbench

Memory and I/O responder for the multi-cycle MIPS datapath. It answers the controller's MemRead/MemWrite strobes with a fixed one-cycle read latency. It decodes each byte address into word RAM, two input ports (0xFFF8, 0xFFFC) or the output port (0xFFFC). It sits between the datapath's address mux (IorD) and the board switches/LEDs.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/mips_memory_io_if.sv | 26 ++
 rtl/mips_ram.sv | 27 ++
 rtl/mips_memory_io.sv | 108 ++++++++++
 tb/tb_mips_memory_io.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS memory/I-O block:
// memory-mapped port addresses and the address-decode select.
package mips_pkg;

   localparam logic [31:0] INPORT0_ADDR = 32'h0000FFF8;
   localparam logic [31:0] INPORT1_ADDR = 32'h0000FFFC;
   localparam logic [31:0] OUTPORT_ADDR = INPORT1_ADDR;

   typedef enum logic [1:0] {
      SEL_RAM,
      SEL_IN0,
      SEL_IN1,
      SEL_NONE
   } sel_t;

   // Ports are checked before RAM so they stay reachable even with a 16K-word RAM
   function automatic sel_t decode_sel(input logic [31:0] addr, input int unsigned ram_words);
      sel_t sel;
      sel = SEL_NONE;
      if (addr[31:2] == INPORT0_ADDR[31:2]) begin
         sel = SEL_IN0;
      end else if (addr[31:2] == INPORT1_ADDR[31:2]) begin
         sel = SEL_IN1;
      end else if ({2'b00, addr[31:2]} < ram_words) begin
         sel = SEL_RAM;
      end
      return sel;
   endfunction

endpackage

// File: rtl/mips_memory_io_if.sv
// Controller-side memory bus: strobes, address, store data and read data.
interface mips_memory_io_if;

   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;

   modport master (
      output MemRead,
      output MemWrite,
      output addr,
      output wr_data,
      input  rd_data
   );

   modport slave (
      input  MemRead,
      input  MemWrite,
      input  addr,
      input  wr_data,
      output rd_data
   );

endinterface

// File: rtl/mips_ram.sv
// Single-port word RAM with write enable and registered read; the read
// register only changes on a read, so it holds its value otherwise.
module mips_ram #(
   parameter int    RAM_WORDS = 256,
   parameter string INIT_FILE = "",
   localparam int   AW        = $clog2(RAM_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      if (re) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/mips_memory_io.sv
// Memory and I/O responder for the multi-cycle MIPS datapath: word RAM,
// two switch-fed input ports and an LED output port, one-cycle read latency.
module mips_memory_io
   import mips_pkg::*;
#(
   parameter int    RAM_WORDS = 256,
   parameter string INIT_FILE = ""
) (
   input  logic                    clk,
   input  logic                    rst,
   mips_memory_io_if.slave         bus,
   input  logic [9:0]              switches,
   input  logic                    inport_en,
   input  logic                    inport_sel,
   output logic [31:0]             outport,
   output logic                    outport_strobe
);

   localparam int AW = $clog2(RAM_WORDS);

   sel_t        sel;
   sel_t        rd_sel_q;
   logic        do_read;
   logic        do_write;
   logic        ram_we;
   logic        ram_re;
   logic        out_wr;
   logic [31:0] ram_q;
   logic [31:0] port_q;
   logic [9:0]  sync1;
   logic [9:0]  sync2;
   logic [31:0] inport0;
   logic [31:0] inport1;

   // A write always wins over a simultaneous read; reset cancels any write in flight
   always_comb begin
      sel      = decode_sel(bus.addr, RAM_WORDS);
      do_write = bus.MemWrite && !rst;
      do_read  = bus.MemRead && !bus.MemWrite && !rst;
      ram_we   = do_write && (sel == SEL_RAM);
      ram_re   = do_read && (sel == SEL_RAM);
      out_wr   = do_write && (sel == SEL_IN1);
   end

   mips_ram #(
      .RAM_WORDS (RAM_WORDS),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .idx   (bus.addr[AW+1:2]),
      .wdata (bus.wr_data),
      .rdata (ram_q)
   );

   // Switch synchronizer and the two input port registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= '0;
         sync2   <= '0;
         inport0 <= '0;
         inport1 <= '0;
      end else begin
         sync1 <= switches;
         sync2 <= sync1;
         if (inport_en) begin
            if (inport_sel) begin
               inport1 <= {22'b0, sync2};
            end else begin
               inport0 <= {22'b0, sync2};
            end
         end
      end
   end

   // Output port register and its one-cycle update pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outport        <= '0;
         outport_strobe <= 1'b0;
      end else begin
         outport_strobe <= out_wr;
         if (out_wr) begin
            outport <= bus.wr_data;
         end
      end
   end

   // Read-side select and port data are captured only on a read, so rd_data
   // holds through idle and write cycles while the IR/MDR load late
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_sel_q <= SEL_NONE;
         port_q   <= '0;
      end else if (do_read) begin
         rd_sel_q <= sel;
         case (sel)
            SEL_IN0: port_q <= inport0;
            SEL_IN1: port_q <= inport1;
            default: port_q <= '0;
         endcase
      end
   end

   assign bus.rd_data = (rd_sel_q == SEL_RAM) ? ram_q : port_q;

endmodule

// File: tb/tb_mips_memory_io.sv
// Directed self-checking bench for mips_memory_io: a vector table for RAM
// and decode behaviour plus hand sequences for ports, outport and reset.
module tb_mips_memory_io;

   logic        clk;
   logic        rst;
   logic [9:0]  switches;
   logic        inport_en;
   logic        inport_sel;
   logic [31:0] outport;
   logic        outport_strobe;

   int total_checks;
   int passed_checks;

   mips_memory_io_if bus ();

   mips_memory_io #(
      .RAM_WORDS (256),
      .INIT_FILE ("")
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .switches       (switches),
      .inport_en      (inport_en),
      .inport_sel     (inport_sel),
      .outport        (outport),
      .outport_strobe (outport_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [31:0] exp_out;
   } vec_t;

   vec_t vecs [19];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
      bus.MemRead  = rd;
      bus.MemWrite = wr;
      bus.addr     = addr;
      bus.wr_data  = wdata;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      total_checks++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end else begin
         passed_checks++;
      end
   endtask

   initial begin
      total_checks  = 0;
      passed_checks = 0;
      switches      = '0;
      inport_en     = 1'b0;
      inport_sel    = 1'b0;
      rst           = 1'b1;
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);

      // RAM_WORDS*4-4 = 0x3FC is the last word; 0x400 is the first unmapped word
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h7777_7777, 32'h0000_0000, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0000_0014, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0};
      vecs[5]  = '{1'b0, 1'b0, 32'h0000_8000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0};
      vecs[6]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000, 32'h1111_1111, 32'h0};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_8000, 32'hCAFE_F00D, 32'h1111_1111, 32'h0};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 32'h0};
      vecs[11] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0};
      vecs[13] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0BAD_F00D, 32'hA5A5_A5A5, 32'h0};
      vecs[14] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0BAD_F00D, 32'h0};
      vecs[15] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 32'h0};
      vecs[16] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h7777_7777, 32'h0};
      vecs[17] = '{1'b0, 1'b1, 32'h0000_FFF8, 32'hFFFF_FFFF, 32'h7777_7777, 32'h0};
      vecs[18] = '{1'b1, 1'b0, 32'h0000_FFF8, 32'h0000_0000, 32'h0000_0000, 32'h0};

      // Reset state
      tick();
      tick();
      check_output("reset rd_data", bus.rd_data, 32'h0);
      check_output("reset outport", outport, 32'h0);
      check_output("reset outport_strobe", {31'b0, outport_strobe}, 32'h0);

      // Write to outport while reset is held must be dropped
      apply_stimulus(1'b0, 1'b1, 32'h0000_FFFC, 32'h0000_0055);
      tick();
      check_output("write under reset outport", outport, 32'h0);
      check_output("write under reset strobe", {31'b0, outport_strobe}, 32'h0);
      rst = 1'b0;
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      check_output("after reset release outport", outport, 32'h0);

      // Table-driven RAM and decode vectors
      for (int i = 0; i < 19; i++) begin
         apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         tick();
         check_output($sformatf("vec%0d rd_data", i), bus.rd_data, vecs[i].exp_rd);
         check_output($sformatf("vec%0d outport", i), outport, vecs[i].exp_out);
      end
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);

      // Switches into inport0 after the 2-flop synchronizer
      switches = 10'h2A5;
      tick();
      tick();
      inport_en  = 1'b1;
      inport_sel = 1'b0;
      tick();
      inport_en = 1'b0;
      apply_stimulus(1'b1, 1'b0, 32'h0000_FFF8, 32'h0);
      tick();
      check_output("inport0 read", bus.rd_data, 32'h0000_02A5);

      // Loading inport1 in the same cycle as reading it returns the old value
      inport_en  = 1'b1;
      inport_sel = 1'b1;
      apply_stimulus(1'b1, 1'b0, 32'h0000_FFFC, 32'h0);
      tick();
      check_output("inport1 same-cycle read", bus.rd_data, 32'h0);
      inport_en = 1'b0;
      tick();
      check_output("inport1 read", bus.rd_data, 32'h0000_02A5);

      // Output port write and strobe pulse
      apply_stimulus(1'b0, 1'b1, 32'h0000_FFFC, 32'h1234_5678);
      tick();
      check_output("outport value", outport, 32'h1234_5678);
      check_output("outport strobe high", {31'b0, outport_strobe}, 32'h1);
      check_output("rd_data hold on outport write", bus.rd_data, 32'h0000_02A5);
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      check_output("outport strobe low", {31'b0, outport_strobe}, 32'h0);
      check_output("outport hold", outport, 32'h1234_5678);
      apply_stimulus(1'b1, 1'b0, 32'h0000_FFFC, 32'h0);
      tick();
      check_output("read 0xFFFC after outport write", bus.rd_data, 32'h0000_02A5);

      // Asynchronous reset in the middle of an outport write
      apply_stimulus(1'b0, 1'b1, 32'h0000_FFFC, 32'h0000_0055);
      rst = 1'b1;
      #1;
      check_output("async reset outport", outport, 32'h0);
      check_output("async reset rd_data", bus.rd_data, 32'h0);
      tick();
      check_output("reset held outport", outport, 32'h0);
      check_output("reset held strobe", {31'b0, outport_strobe}, 32'h0);
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      tick();
      check_output("post reset outport", outport, 32'h0);
      check_output("post reset strobe", {31'b0, outport_strobe}, 32'h0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
